// File: rtl/edge_filter_pkg.sv
// ---------------------------------------------------------------------------
// edge_filter_pkg
// Purpose : small helpers used by the edge_filter input conditioner.
//           edge_strobe_t bundles the rise/fall strobe pair, which are always
//           produced together, and cnt_width() sizes the qualification
//           counter.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package edge_filter_pkg;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_strobe_t;

  // The counter must be able to hold the value FILTER_CYCLES-1.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain
// Purpose : multi-flop synchroniser that brings an asynchronous bit into the
//           i_clk domain. It is reusable at any crossing point. The flops are
//           clocked every cycle. A synchronous reset forces every stage to
//           RESET_VAL so that stale contents are discarded.
// Ports   : i_clk   - clock
//           i_reset - synchronous, active-high reset
//           i_d     - asynchronous input
//           o_q     - synchronised output (last stage)
// ---------------------------------------------------------------------------
module sync_chain #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_stage;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stage <= {DEPTH{RESET_VAL}};
    end else begin
      r_stage <= {r_stage[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/edge_filter.sv
// ---------------------------------------------------------------------------
// edge_filter
// Purpose : conditions one asynchronous bus/slot-card input. The input is
//           synchronised, and any new value must persist for FILTER_CYCLES
//           consecutive qualifying ticks before it is accepted as the
//           filtered level. Single-cycle rise/fall strobes accompany each
//           accepted change and drive a set/reset flag stage directly.
// Ports   : clk   - sole clock
//           reset - synchronous, active-high reset
//           din   - asynchronous raw input
//           tick  - sample qualifier (tie high for per-clock filtering)
//           level - filtered level (registered)
//           rise  - one-clk pulse coincident with level going 0->1
//           fall  - one-clk pulse coincident with level going 1->0
// ---------------------------------------------------------------------------
module edge_filter
  import edge_filter_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int              CNT_W    = cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic             w_sq;
  logic             w_differs;
  logic             w_accept;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  edge_strobe_t     r_strobe;

  // Synchroniser stages
  sync_chain #(
    .DEPTH     (SYNC_STAGES),
    .RESET_VAL (RESET_LEVEL)
  ) u_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (din),
    .o_q     (w_sq)
  );

  // Qualification: the final tick of an unbroken run of disagreement accepts
  // the synchronised value.
  assign w_differs = (w_sq != r_level);
  assign w_accept  = w_differs & tick & (r_cnt == CNT_LAST);

  // Counter, level and strobe registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level  <= RESET_LEVEL;
      r_cnt    <= '0;
      r_strobe <= '0;
    end else begin
      r_strobe <= '0;
      if (!w_differs) begin
        // Any return to the accepted value restarts qualification.
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level       <= w_sq;
        r_cnt         <= '0;
        r_strobe.rise <= w_sq;
        r_strobe.fall <= ~w_sq;
      end else if (tick) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level = r_level;
  assign rise  = r_strobe.rise;
  assign fall  = r_strobe.fall;

endmodule

// File: tb/tb_edge_filter.sv
// ---------------------------------------------------------------------------
// tb_edge_filter
// Purpose : self-checking bench for edge_filter. It covers three parameter
//           sets driven by shared inputs, a behavioural reference model, a
//           downstream set/reset flag, and directed checks for latency,
//           glitches, sparse ticks and reset.
// Ports   : none
// ---------------------------------------------------------------------------
module tb_edge_filter;

  localparam int NI = 3;
  localparam int   P_S  [NI] = '{2, 2, 3};
  localparam int   P_F  [NI] = '{4, 4, 1};
  localparam logic P_RL [NI] = '{1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;
  logic tick = 1'b1;
  logic [NI-1:0] lvl, rs, fl;

  always #5 clk = ~clk;

  edge_filter #(.SYNC_STAGES(2), .FILTER_CYCLES(4), .RESET_LEVEL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .din(din), .tick(tick),
    .level(lvl[0]), .rise(rs[0]), .fall(fl[0]));
  edge_filter #(.SYNC_STAGES(2), .FILTER_CYCLES(4), .RESET_LEVEL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .din(din), .tick(tick),
    .level(lvl[1]), .rise(rs[1]), .fall(fl[1]));
  edge_filter #(.SYNC_STAGES(3), .FILTER_CYCLES(1), .RESET_LEVEL(1'b0)) dut2 (
    .clk(clk), .reset(reset), .din(din), .tick(tick),
    .level(lvl[2]), .rise(rs[2]), .fall(fl[2]));

  // Downstream flag stage: set on a rising edge of s, clear on a rising edge of r.
  logic fq, fps, fpr;
  always @(posedge clk) begin
    if (reset) begin
      fq <= 1'b0; fps <= 1'b0; fpr <= 1'b0;
    end else begin
      fps <= rs[0];
      fpr <= fl[0];
      if (rs[0] && !fps) fq <= 1'b1;
      else if (fl[0] && !fpr) fq <= 1'b0;
    end
  end

  // Reference model: input history plus a count of ticks of unbroken disagreement.
  logic [7:0] m_hist  [NI];
  logic       m_level [NI];
  int         m_run   [NI];
  logic       m_rise  [NI];
  logic       m_fall  [NI];

  int   errors = 0;
  int   checks = 0;
  int   n_rise, n_fall;
  logic lvl_prev;
  logic flag_en = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int i);
    logic seen;
    if (reset) begin
      m_hist[i]  = {8{P_RL[i]}};
      m_level[i] = P_RL[i];
      m_run[i]   = 0;
      m_rise[i]  = 1'b0;
      m_fall[i]  = 1'b0;
    end else begin
      // The value the filter sees is din as it was P_S clocks ago.
      seen       = m_hist[i][P_S[i]-1];
      m_rise[i]  = 1'b0;
      m_fall[i]  = 1'b0;
      if (seen == m_level[i]) begin
        m_run[i] = 0;
      end else if (tick) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] >= P_F[i]) begin
          m_level[i] = seen;
          m_run[i]   = 0;
          if (seen) m_rise[i] = 1'b1;
          else      m_fall[i] = 1'b1;
        end
      end
      m_hist[i] = {m_hist[i][6:0], din};
    end
  endtask

  // One clock: apply inputs, advance the model, then check after the edge.
  task automatic cyc(input logic d, input logic t, input logic r);
    din = d; tick = t; reset = r;
    for (int i = 0; i < NI; i++) model_step(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("level[%0d]", i), lvl[i], m_level[i]);
      chk($sformatf("rise[%0d]", i),  rs[i],  m_rise[i]);
      chk($sformatf("fall[%0d]", i),  fl[i],  m_fall[i]);
    end
    if (flag_en && !r) chk("flag_q", fq, lvl_prev);
    if (rs[0]) n_rise++;
    if (fl[0]) n_fall++;
    lvl_prev = lvl[0];
    flag_en  = 1'b1;
  endtask

  task automatic run(input logic d, input logic t, input int n);
    for (int k = 0; k < n; k++) cyc(d, t, 1'b0);
  endtask

  initial begin
    int len;
    logic d;

    // Reset with din=0. Instance 1 (RESET_LEVEL=1) holds 1 during reset.
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("rst_level0", lvl[0], 1'b0);
    chk("rst_level1", lvl[1], 1'b1);
    chk("rst_rise0", rs[0], 1'b0);
    // Release: no strobe at release; instance 1 falls at edge 6.
    cyc(1'b0, 1'b1, 1'b0);
    chk("rel_nostrobe1", fl[1], 1'b0);
    chk("rel_level1", lvl[1], 1'b1);
    run(1'b0, 1'b1, 4);
    chk("rel_e5_level1", lvl[1], 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("rel_e6_fall1", fl[1], 1'b1);
    chk("rel_e6_level1", lvl[1], 1'b0);

    // Basic rise: reset, then din=1. Level and rise appear at edge 6.
    cyc(1'b0, 1'b1, 1'b1);
    run(1'b1, 1'b1, 5);
    chk("basic_e5_level", lvl[0], 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("basic_e6_level", lvl[0], 1'b1);
    chk("basic_e6_rise", rs[0], 1'b1);
    chk("basic_e6_fall", fl[0], 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("basic_e7_rise", rs[0], 1'b0);
    run(1'b1, 1'b1, 3);
    // Basic fall: the pulse appears 6 edges after din drops.
    run(1'b0, 1'b1, 5);
    chk("basic_fall_e5", fl[0], 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("basic_fall_e6", fl[0], 1'b1);
    chk("basic_fall_lvl", lvl[0], 1'b0);
    run(1'b0, 1'b1, 4);

    // A 3-clk glitch is rejected.
    n_rise = 0; n_fall = 0;
    run(1'b1, 1'b1, 3);
    run(1'b0, 1'b1, 12);
    chk("glitch3_level", lvl[0], 1'b0);
    chk("glitch3_nostrobe", (n_rise + n_fall) == 0, 1'b1);

    // A 4-clk pulse is accepted, then returns low.
    n_rise = 0; n_fall = 0;
    run(1'b1, 1'b1, 4);
    run(1'b0, 1'b1, 12);
    chk("pulse4_rise", n_rise == 1, 1'b1);
    chk("pulse4_fall", n_fall == 1, 1'b1);

    // Sparse tick (every 4th clk): a single 1-clk-wide rise.
    n_rise = 0;
    for (int k = 0; k < 40; k++) cyc(1'b1, (k % 4) == 3, 1'b0);
    chk("sparse_rise_once", n_rise == 1, 1'b1);
    chk("sparse_level", lvl[0], 1'b1);
    run(1'b0, 1'b1, 10);

    // Reset with the counter at 3 of 4, then full requalification.
    run(1'b1, 1'b1, 5);
    n_rise = 0;
    cyc(1'b1, 1'b1, 1'b1);
    chk("midrst_level", lvl[0], 1'b0);
    chk("midrst_rise", rs[0], 1'b0);
    run(1'b1, 1'b1, 5);
    chk("midrst_e5_level", lvl[0], 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("midrst_e6_rise", rs[0], 1'b1);
    chk("midrst_nopre", n_rise == 1, 1'b1);
    run(1'b1, 1'b1, 3);

    // Chain to flag: toggle din every 10 clks. The flag is checked each cycle.
    n_rise = 0; n_fall = 0;
    for (int p = 0; p < 8; p++) run(p[0], 1'b1, 10);
    chk("chain_rises", n_rise == 4, 1'b1);
    chk("chain_falls", n_fall == 4, 1'b1);

    // Random runs with random ticks and occasional reset.
    for (int k = 0; k < 120; k++) begin
      d   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++)
        cyc(d, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
